// File: rtl/reg_file_scoreboard_if.sv
// Decode/writeback bus of the register file with integrated pending scoreboard.
// The master side (decode + writeback) drives writes, issue marks and read
// indices; the slave side (the register file) returns read data, pending flags
// and the ready indication.
interface reg_file_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     writeEnable;
  logic [ADDR_W-1:0]        writeAddress;
  logic [DATA_W-1:0]        writeData;
  logic [NUM_RD*ADDR_W-1:0] readAddress;
  logic [NUM_RD*DATA_W-1:0] readData;
  logic [NUM_RD-1:0]        readPending;
  logic                     issueValid;
  logic [ADDR_W-1:0]        issueAddress;
  logic                     ready;

  modport master (
    output writeEnable, writeAddress, writeData, readAddress,
           issueValid, issueAddress,
    input  readData, readPending, ready
  );

  modport slave (
    input  writeEnable, writeAddress, writeData, readAddress,
           issueValid, issueAddress,
    output readData, readPending, ready
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Multi-read-port register file with a per-register pending scoreboard and a
// post-reset clear sweep. Writes and issue marks are accepted only once the
// sweep has zeroed every register; until then reads return zero.
module reg_file_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input logic                  clk,
  input logic                  rst_n,
  reg_file_scoreboard_if.slave bus
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              ready_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_next;

  logic              running;
  logic              write_drop;
  logic              write_live;
  logic              issue_live;
  logic [NUM_RD*DATA_W-1:0] read_data;
  logic [NUM_RD-1:0]        read_pending;

  assign running    = (state == RUN);
  assign write_drop = (ZERO_REG != 0) && (bus.writeAddress == '0);
  assign write_live = running && bus.writeEnable && !write_drop;
  assign issue_live = running && bus.issueValid &&
                      !((ZERO_REG != 0) && (bus.issueAddress == '0));

  // Clear sequencer: sweep cnt over every register, then enter RUN for good.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == ADDR_W'(DEPTH - 1)) begin
        state   <= RUN;
        ready_q <= 1'b1;
      end
    end
  end

  assign bus.ready = ready_q;

  // Storage: zeroed one entry per cycle by the sweep, then written by writeback.
  // NOTE: the array deliberately has no reset; the sweep initialises it, which
  // keeps it mappable onto plain RAM/flop arrays without a reset tree.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (write_live) begin
      mem[bus.writeAddress] <= bus.writeData;
    end
  end

  // Scoreboard next state: writeback clears first so a same-cycle issue wins.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    pending_next = pending;
    if (running && bus.writeEnable) begin
      pending_next[bus.writeAddress] = 1'b0;
    end
    if (issue_live) begin
      pending_next[bus.issueAddress] = 1'b1;
    end
  end

  // Pending vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Read ports: zero while clearing, hardwired reg 0, optional writeback bypass.
  always_comb begin
    read_data    = '0;
    read_pending = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [ADDR_W-1:0] ra;
      ra = bus.readAddress[k*ADDR_W +: ADDR_W];
      if (!running) begin
        read_data[k*DATA_W +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        read_data[k*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && write_live && (bus.writeAddress == ra)) begin
        read_data[k*DATA_W +: DATA_W] = bus.writeData;
      end else begin
        read_data[k*DATA_W +: DATA_W] = mem[ra];
        read_pending[k]               = pending[ra];
      end
    end
  end

  assign bus.readData    = read_data;
  assign bus.readPending = read_pending;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench: two instances share one stimulus stream, dut0 with the
// writeback bypass enabled and dut1 without, so both read behaviours are
// compared against hand-computed values each vector.
module tb_reg_file_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  reg_file_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus0 ();
  reg_file_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus1 ();

  assign bus1.writeEnable  = bus0.writeEnable;
  assign bus1.writeAddress = bus0.writeAddress;
  assign bus1.writeData    = bus0.writeData;
  assign bus1.readAddress  = bus0.readAddress;
  assign bus1.issueValid   = bus0.issueValid;
  assign bus1.issueAddress = bus0.issueAddress;

  reg_file_scoreboard #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  reg_file_scoreboard #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic drive_idle();
    bus0.writeEnable  = 1'b0;
    bus0.writeAddress = '0;
    bus0.writeData    = '0;
    bus0.issueValid   = 1'b0;
    bus0.issueAddress = '0;
  endtask

  task automatic set_reads(input int a0, input int a1);
    bus0.readAddress = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  // Releases reset at a negedge and checks ready is low for 31 cycles, high on the 32nd.
  task automatic sweep_after_release(input string tag);
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      vectors++;
      if (bus0.ready !== (i == 32) || bus1.ready !== (i == 32)) begin
        miscompares++;
        $display("FAIL %s_ready cycle %0d: got %b/%b want %b", tag, i,
                 bus0.ready, bus1.ready, (i == 32));
      end
      if (i < 32) begin
        vectors++;
        if (bus0.readData !== '0 || bus1.readData !== '0 || bus0.readPending !== '0) begin
          miscompares++;
          $display("FAIL %s_forced_zero cycle %0d: got %h/%h pend %b want 0", tag, i,
                   bus0.readData, bus1.readData, bus0.readPending);
        end
      end
    end
  endtask

  // Every register must read 0 and not pending, on both ports of both instances.
  task automatic expect_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      set_reads(a, 31 - a);
      #1;
      vectors++;
      if ({bus0.readData, bus1.readData} !== '0 ||
          {bus0.readPending, bus1.readPending} !== '0) begin
        miscompares++;
        $display("FAIL %s reg %0d: got %h/%h pend %b/%b want 0", tag, a,
                 bus0.readData, bus1.readData, bus0.readPending, bus1.readPending);
      end
    end
  endtask

  // T1: preload DEADBEEF with pending marks, reset, verify the sweep clears everything.
  task automatic test_reset();
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      bus0.writeEnable  = 1'b1;
      bus0.writeAddress = ADDR_W'(a);
      bus0.writeData    = 32'hDEAD_BEEF;
      bus0.issueValid   = 1'b1;
      bus0.issueAddress = ADDR_W'(a);
    end
    @(negedge clk);
    drive_idle();
    set_reads(1, 31);
    #1;
    vectors++;
    if (bus0.readData !== {2{32'hDEAD_BEEF}} || bus1.readData !== {2{32'hDEAD_BEEF}}) begin
      miscompares++;
      $display("FAIL preload_data: got %h/%h want deadbeef x2", bus0.readData, bus1.readData);
    end
    vectors++;
    if (bus0.readPending !== 2'b11 || bus1.readPending !== 2'b11) begin
      miscompares++;
      $display("FAIL preload_pending: got %b/%b want 11", bus0.readPending, bus1.readPending);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus0.ready !== 1'b0 || bus1.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b/%b want 0", bus0.ready, bus1.ready);
    end
    @(negedge clk);
    sweep_after_release("sweep");
    expect_all_zero("sweep_zero");
  endtask

  // T2: reset at sweep cycle 10 restarts a full 32-cycle sweep.
  task automatic test_mid_sweep_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus0.ready !== 1'b0 || bus1.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_ready: got %b/%b want 0", bus0.ready, bus1.ready);
    end
    @(negedge clk);
    sweep_after_release("mid_sweep");
    expect_all_zero("mid_sweep_zero");
  endtask

  // T3: write reg5, both ports read it; bypass instance sees it in the write cycle.
  task automatic test_write_read();
    @(negedge clk);
    bus0.writeEnable  = 1'b1;
    bus0.writeAddress = 5'd5;
    bus0.writeData    = 32'h1234_5678;
    set_reads(5, 5);
    #1;
    vectors++;
    if (bus0.readData !== {2{32'h1234_5678}}) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: got %h want 12345678 x2", bus0.readData);
    end
    vectors++;
    if (bus1.readData !== '0) begin
      miscompares++;
      $display("FAIL nobypass_same_cycle: got %h want 0", bus1.readData);
    end
    @(negedge clk);
    drive_idle();
    #1;
    vectors++;
    if (bus0.readData !== {2{32'h1234_5678}} || bus1.readData !== {2{32'h1234_5678}}) begin
      miscompares++;
      $display("FAIL write_next_cycle: got %h/%h want 12345678 x2", bus0.readData, bus1.readData);
    end
  endtask

  // T4: write and issue to reg0 are dropped.
  task automatic test_zero_reg();
    @(negedge clk);
    bus0.writeEnable  = 1'b1;
    bus0.writeAddress = 5'd0;
    bus0.writeData    = 32'hFFFF_FFFF;
    bus0.issueValid   = 1'b1;
    bus0.issueAddress = 5'd0;
    set_reads(0, 0);
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if ({bus0.readData, bus1.readData} !== '0 ||
          {bus0.readPending, bus1.readPending} !== '0) begin
        miscompares++;
        $display("FAIL zero_reg cycle %0d: got %h/%h pend %b/%b want 0", c,
                 bus0.readData, bus1.readData, bus0.readPending, bus1.readPending);
      end
      @(negedge clk);
      drive_idle();
    end
  endtask

  // T5: issue reg7, three idle cycles pending, then writeback clears it.
  task automatic test_scoreboard();
    @(negedge clk);
    bus0.issueValid   = 1'b1;
    bus0.issueAddress = 5'd7;
    set_reads(7, 6);
    #1;
    vectors++;
    if (bus0.readPending !== 2'b00 || bus1.readPending !== 2'b00) begin
      miscompares++;
      $display("FAIL issue_cycle_pending: got %b/%b want 00", bus0.readPending, bus1.readPending);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_idle();
      #1;
      vectors++;
      if (bus0.readPending !== 2'b01 || bus1.readPending !== 2'b01) begin
        miscompares++;
        $display("FAIL pending_idle cycle %0d: got %b/%b want 01", c,
                 bus0.readPending, bus1.readPending);
      end
    end
    @(negedge clk);
    bus0.writeEnable  = 1'b1;
    bus0.writeAddress = 5'd7;
    bus0.writeData    = 32'hA5A5_A5A5;
    #1;
    vectors++;
    if (bus0.readPending[0] !== 1'b0 || bus0.readData[31:0] !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL bypass_write_cycle: got pend %b data %h want 0 a5a5a5a5",
               bus0.readPending[0], bus0.readData[31:0]);
    end
    vectors++;
    if (bus1.readPending[0] !== 1'b1 || bus1.readData[31:0] !== 32'h0) begin
      miscompares++;
      $display("FAIL nobypass_write_cycle: got pend %b data %h want 1 0",
               bus1.readPending[0], bus1.readData[31:0]);
    end
    @(negedge clk);
    drive_idle();
    #1;
    vectors++;
    if (bus0.readPending !== 2'b00 || bus1.readPending !== 2'b00 ||
        bus1.readData[31:0] !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL after_write: got pend %b/%b data %h want 00/00 a5a5a5a5",
               bus0.readPending, bus1.readPending, bus1.readData[31:0]);
    end
  endtask

  // T6: issue and writeback to reg9 in the same cycle: issue wins, data updated.
  task automatic test_collision();
    @(negedge clk);
    bus0.writeEnable  = 1'b1;
    bus0.writeAddress = 5'd9;
    bus0.writeData    = 32'h0BAD_F00D;
    bus0.issueValid   = 1'b1;
    bus0.issueAddress = 5'd9;
    set_reads(9, 9);
    @(negedge clk);
    drive_idle();
    #1;
    vectors++;
    if (bus0.readPending !== 2'b11 || bus1.readPending !== 2'b11) begin
      miscompares++;
      $display("FAIL collision_pending: got %b/%b want 11", bus0.readPending, bus1.readPending);
    end
    vectors++;
    if (bus0.readData !== {2{32'h0BAD_F00D}} || bus1.readData !== {2{32'h0BAD_F00D}}) begin
      miscompares++;
      $display("FAIL collision_data: got %h/%h want 0badf00d x2", bus0.readData, bus1.readData);
    end
  endtask

  initial begin
    drive_idle();
    set_reads(0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    sweep_after_release("init_sweep");
    test_reset();
    test_mid_sweep_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
